// File: rtl/serial_cmp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_cmp_ctrl_if
// Purpose  : Start/busy/done request bus between a requester and serial_cmp_ctrl.
// Revision : 1.0 - initial release
// ============================================================================

interface serial_cmp_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             agreb;
    logic             aeqb;
    logic             aleb;

    modport master (
        output start, a, b,
        input  busy, done, agreb, aeqb, aleb
    );

    modport slave (
        input  start, a, b,
        output busy, done, agreb, aeqb, aleb
    );
endinterface

`default_nettype wire

// File: rtl/serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_cmp_ctrl
// Purpose  : Multi-cycle magnitude comparator scanning 2-bit slices MSB first.
//            SERIAL_CMP_EARLY_EXIT_EN: stop on first differing slice, else
//            walk all slices for constant latency.
// Revision : 1.0 - initial release
// ============================================================================

module serial_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    serial_cmp_ctrl_if.slave bus
);
    localparam int S  = WIDTH / 2;
    localparam int KW = (S > 1) ? $clog2(S) : 1;
    localparam logic [KW-1:0] c_K_MAX = KW'(S - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [KW-1:0]    k_q;
    logic             busy_q;
    logic             done_q;
    logic             agreb_q;
    logic             aeqb_q;
    logic             aleb_q;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
    logic             pend_v_q;
    logic             pend_gt_q;
`endif

    logic [1:0] w_a_sl;
    logic [1:0] w_b_sl;
    logic       w_gt;
    logic       w_lt;
    logic       w_finish;
    logic       w_res_gt;
    logic       w_res_lt;

    assign w_a_sl = 2'(a_q >> {k_q, 1'b0});
    assign w_b_sl = 2'(b_q >> {k_q, 1'b0});

    // Shared 2-bit greater-than slice; less-than is the operand-swapped twin.
    assign w_gt = (w_a_sl[1] & ~w_b_sl[1]) | (w_a_sl[0] & ~w_b_sl[1] & ~w_b_sl[0])
                | (w_a_sl[1] & w_a_sl[0] & ~w_b_sl[0]);
    assign w_lt = (w_b_sl[1] & ~w_a_sl[1]) | (w_b_sl[0] & ~w_a_sl[1] & ~w_a_sl[0])
                | (w_b_sl[1] & w_b_sl[0] & ~w_a_sl[0]);

    always_comb begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        w_finish = w_gt | w_lt | (k_q == '0);
        w_res_gt = w_gt;
        w_res_lt = w_lt;
`else
        w_finish = (k_q == '0);
        w_res_gt = pend_v_q ? pend_gt_q  : w_gt;
        w_res_lt = pend_v_q ? ~pend_gt_q : w_lt;
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            k_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            agreb_q   <= 1'b0;
            aeqb_q    <= 1'b0;
            aleb_q    <= 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            pend_v_q  <= 1'b0;
            pend_gt_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        k_q      <= c_K_MAX;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
                        pend_v_q <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    if (w_finish) begin
                        agreb_q <= w_res_gt;
                        aleb_q  <= w_res_lt;
                        aeqb_q  <= ~(w_res_gt | w_res_lt);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        k_q <= k_q - KW'(1);
                    end
`ifndef SERIAL_CMP_EARLY_EXIT_EN
                    // Only the most-significant differing slice decides the result.
                    if (!pend_v_q && (w_gt || w_lt)) begin
                        pend_v_q  <= 1'b1;
                        pend_gt_q <= w_gt;
                    end
`endif
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.agreb = agreb_q;
    assign bus.aeqb  = aeqb_q;
    assign bus.aleb  = aleb_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_cmp_ctrl
// Purpose  : Self-checking bench for serial_cmp_ctrl at WIDTH 2, 8 and 16.
// Revision : 1.0 - initial release
// ============================================================================

module tb_serial_cmp_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_cmp_ctrl_if #(.WIDTH(2))  if2  ();
    serial_cmp_ctrl_if #(.WIDTH(8))  if8  ();
    serial_cmp_ctrl_if #(.WIDTH(16)) if16 ();

    serial_cmp_ctrl #(.WIDTH(2))  dut2  (.clk_i(clk), .reset_i(rst), .bus(if2.slave));
    serial_cmp_ctrl #(.WIDTH(8))  dut8  (.clk_i(clk), .reset_i(rst), .bus(if8.slave));
    serial_cmp_ctrl #(.WIDTH(16)) dut16 (.clk_i(clk), .reset_i(rst), .bus(if16.slave));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Slices examined: first differing 2-bit slice counted from the MSB, or all.
    function automatic int model_n(int w, logic [15:0] a, logic [15:0] b);
        int s     = w / 2;
        int first = s;
        for (int i = s - 1; i >= 0; i--) begin
            if (a[2*i +: 2] != b[2*i +: 2]) begin
                first = s - i;
                break;
            end
        end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        return first;
`else
        return s;
`endif
    endfunction

    function automatic logic [2:0] model_flags(logic [15:0] a, logic [15:0] b);
        if (a > b)       return 3'b100;
        else if (a == b) return 3'b010;
        else             return 3'b001;
    endfunction

    // Runs one 8-bit compare and reports what was observed; callers check.
    task automatic compare8(input logic [7:0] a, input logic [7:0] b, output int lat,
                            output int busy_cyc, output logic [2:0] flags, output int pulses);
        if8.a = a; if8.b = b; if8.start = 1'b1;
        tick;
        if8.start = 1'b0;
        lat = -1; busy_cyc = 0; pulses = 0; flags = 3'b000;
        for (int c = 1; c <= 20; c++) begin
            if (if8.busy) busy_cyc++;
            tick;
            if (if8.done) begin
                pulses++;
                if (lat < 0) begin
                    lat   = c;
                    flags = {if8.agreb, if8.aeqb, if8.aleb};
                end
            end
            if (lat >= 0 && c >= lat + 2) break;
        end
    endtask

    task automatic test_reset;
        logic [14:0] outs;
        rst = 1'b1;
        tick; tick;
        outs = {if2.busy, if2.done, if2.agreb, if2.aeqb, if2.aleb,
                if8.busy, if8.done, if8.agreb, if8.aeqb, if8.aleb,
                if16.busy, if16.done, if16.agreb, if16.aeqb, if16.aleb};
        n_checks++;
        if (outs !== 15'b0) begin
            n_fail++; $display("FAIL reset_outputs got=%b exp=0", outs);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_gt_msb;
        int lat, busy_cyc, pulses; logic [2:0] fl;
        int exp_n;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        exp_n = 1;
`else
        exp_n = 4;
`endif
        compare8(8'hC3, 8'h43, lat, busy_cyc, fl, pulses);
        n_checks++;
        if (lat !== exp_n) begin n_fail++; $display("FAIL gt_latency got=%0d exp=%0d", lat, exp_n); end
        n_checks++;
        if (fl !== 3'b100) begin n_fail++; $display("FAIL gt_flags got=%b exp=100", fl); end
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL gt_done_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_lt_lsb;
        int lat, busy_cyc, pulses; logic [2:0] fl;
        compare8(8'h12, 8'h13, lat, busy_cyc, fl, pulses);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL lt_latency got=%0d exp=4", lat); end
        n_checks++;
        if (busy_cyc !== 4) begin n_fail++; $display("FAIL lt_busy_cycles got=%0d exp=4", busy_cyc); end
        n_checks++;
        if (fl !== 3'b001) begin n_fail++; $display("FAIL lt_flags got=%b exp=001", fl); end
    endtask

    task automatic test_back_to_back;
        int lat, exp_n;
        if8.a = 8'hA5; if8.b = 8'hA5; if8.start = 1'b1;
        tick;
        if8.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (if8.done) begin lat = c; break; end
        end
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL eq_latency got=%0d exp=4", lat); end
        n_checks++;
        if ({if8.agreb, if8.aeqb, if8.aleb} !== 3'b010) begin
            n_fail++; $display("FAIL eq_flags got=%b exp=010", {if8.agreb, if8.aeqb, if8.aleb});
        end
        tick;
        n_checks++;
        if (if8.done !== 1'b0) begin n_fail++; $display("FAIL eq_done_width got=%b exp=0", if8.done); end
        if8.a = 8'hFF; if8.b = 8'h00; if8.start = 1'b1;
        tick;
        if8.start = 1'b0;
        n_checks++;
        if ({if8.busy, if8.aeqb} !== 2'b11) begin
            n_fail++; $display("FAIL b2b_accept_hold got=%b exp=11", {if8.busy, if8.aeqb});
        end
        exp_n = model_n(8, 16'h00FF, 16'h0000);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (if8.done) begin lat = c; break; end
        end
        n_checks++;
        if (lat !== exp_n) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, exp_n); end
        n_checks++;
        if ({if8.agreb, if8.aeqb, if8.aleb} !== 3'b100) begin
            n_fail++; $display("FAIL b2b_flags got=%b exp=100", {if8.agreb, if8.aeqb, if8.aleb});
        end
        tick; tick;
    endtask

    task automatic test_start_held;
        int t1 = -1, t2 = -1, pulses = 0, n2;
        logic [2:0] f1 = 3'b000, f2 = 3'b000;
        n2 = model_n(8, 16'h0080, 16'h007F);
        if8.a = 8'h12; if8.b = 8'h13; if8.start = 1'b1;
        tick;
        if8.a = 8'h80; if8.b = 8'h7F;
        for (int c = 1; c <= 6 + n2; c++) begin
            tick;
            if (if8.done) begin
                pulses++;
                if (t1 < 0) begin t1 = c; f1 = {if8.agreb, if8.aeqb, if8.aleb}; end
                else        begin t2 = c; f2 = {if8.agreb, if8.aeqb, if8.aleb}; end
            end
        end
        if8.start = 1'b0;
        n_checks++;
        if (t1 !== 4 || f1 !== 3'b001) begin
            n_fail++; $display("FAIL held_first got t=%0d f=%b exp t=4 f=001", t1, f1);
        end
        n_checks++;
        if (t2 !== 6 + n2 || f2 !== 3'b100) begin
            n_fail++; $display("FAIL held_second got t=%0d f=%b exp t=%0d f=100", t2, f2, 6 + n2);
        end
        n_checks++;
        if (pulses !== 2) begin n_fail++; $display("FAIL held_pulses got=%0d exp=2", pulses); end
        tick; tick; tick;
    endtask

    task automatic test_reset_mid_run;
        int lat, busy_cyc, pulses; logic [2:0] fl;
        int stray = 0;
        if8.a = 8'h01; if8.b = 8'h02; if8.start = 1'b1;
        tick;
        if8.start = 1'b0;
        tick; tick;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({if8.busy, if8.done, if8.agreb, if8.aeqb, if8.aleb} !== 5'b0) begin
            n_fail++;
            $display("FAIL abort_outputs got=%b exp=00000",
                     {if8.busy, if8.done, if8.agreb, if8.aeqb, if8.aleb});
        end
        tick;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (if8.done) stray++;
        end
        n_checks++;
        if (stray !== 0) begin n_fail++; $display("FAIL abort_stray_done got=%0d exp=0", stray); end
        compare8(8'h01, 8'h02, lat, busy_cyc, fl, pulses);
        n_checks++;
        if (lat !== 4 || fl !== 3'b001) begin
            n_fail++; $display("FAIL post_abort got lat=%0d f=%b exp lat=4 f=001", lat, fl);
        end
    endtask

    task automatic test_random;
        logic [15:0] ra, rb;
        int l2, l8, l16;
        for (int it = 0; it < 3000; it++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (16'h1 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            if2.a  = ra[1:0]; if2.b  = rb[1:0];
            if8.a  = ra[7:0]; if8.b  = rb[7:0];
            if16.a = ra;      if16.b = rb;
            if2.start = 1'b1; if8.start = 1'b1; if16.start = 1'b1;
            tick;
            if2.start = 1'b0; if8.start = 1'b0; if16.start = 1'b0;
            l2 = -1; l8 = -1; l16 = -1;
            for (int c = 1; c <= 10; c++) begin
                tick;
                if (l2 < 0 && if2.done) begin
                    l2 = c; n_checks++;
                    if ({if2.agreb, if2.aeqb, if2.aleb} !== model_flags({14'b0, ra[1:0]}, {14'b0, rb[1:0]})) begin
                        n_fail++; $display("FAIL rnd_flags_w2 a=%h b=%h got=%b", ra[1:0], rb[1:0],
                                           {if2.agreb, if2.aeqb, if2.aleb});
                    end
                end
                if (l8 < 0 && if8.done) begin
                    l8 = c; n_checks++;
                    if ({if8.agreb, if8.aeqb, if8.aleb} !== model_flags({8'b0, ra[7:0]}, {8'b0, rb[7:0]})) begin
                        n_fail++; $display("FAIL rnd_flags_w8 a=%h b=%h got=%b", ra[7:0], rb[7:0],
                                           {if8.agreb, if8.aeqb, if8.aleb});
                    end
                end
                if (l16 < 0 && if16.done) begin
                    l16 = c; n_checks++;
                    if ({if16.agreb, if16.aeqb, if16.aleb} !== model_flags(ra, rb)) begin
                        n_fail++; $display("FAIL rnd_flags_w16 a=%h b=%h got=%b", ra, rb,
                                           {if16.agreb, if16.aeqb, if16.aleb});
                    end
                end
                if (l2 >= 0 && l8 >= 0 && l16 >= 0) break;
            end
            n_checks++;
            if (l2 !== model_n(2, {14'b0, ra[1:0]}, {14'b0, rb[1:0]}) ||
                l8 !== model_n(8, {8'b0, ra[7:0]}, {8'b0, rb[7:0]}) ||
                l16 !== model_n(16, ra, rb)) begin
                n_fail++;
                $display("FAIL rnd_latency a=%h b=%h got=%0d/%0d/%0d exp=%0d/%0d/%0d", ra, rb, l2, l8, l16,
                         model_n(2, {14'b0, ra[1:0]}, {14'b0, rb[1:0]}),
                         model_n(8, {8'b0, ra[7:0]}, {8'b0, rb[7:0]}), model_n(16, ra, rb));
            end
            tick;
        end
    endtask

    initial begin
        if2.start = 1'b0;  if2.a = '0;  if2.b = '0;
        if8.start = 1'b0;  if8.a = '0;  if8.b = '0;
        if16.start = 1'b0; if16.a = '0; if16.b = '0;
        test_reset;
        test_gt_msb;
        test_lt_lsb;
        test_back_to_back;
        test_start_held;
        test_reset_mid_run;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
